// File: rtl/mem_access_if.sv
// Byte-serial memory-controller port of the memory stage.
// master: mem_access drives req/we/addr/dout; slave: controller returns din/ack.
interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_dout_o;
  logic [7:0]        mem_din_i;
  logic              mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_dout_o,
    input  mem_din_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_dout_o,
    output mem_din_i, mem_ack_i
  );
endinterface

// File: rtl/mem_access.sv
// Memory stage: byte-serial loads/stores over bus, stall to ctrl, passthrough else.
// Ports: clk/rst, ex_mem inputs, hold_i, mem_wb outputs, stall_req_o, bus (master).
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int OPC_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              hold_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o,
  mem_access_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] buf_q;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic        is_ld;
  logic        is_st;
  logic        is_mem;
  logic [1:0]  last;
  logic [31:0] ld_data;

  assign op     = opcode_i[6:0];
  assign f3     = opcode_i[9:7];
  assign is_ld  = (op == 7'b0000011);
  assign is_st  = (op == 7'b0100011);
  assign is_mem = is_ld | is_st;

  // index of final byte: 1, 2 or 4 bytes; all reserved widths act as word
  always_comb begin
    last = 2'd3;
    unique case (1'b1)
      f3[1:0] == 2'b00: last = 2'd0;
      f3[1:0] == 2'b01: last = 2'd1;
      default: ;
    endcase
  end

  always_comb begin
    ld_data = buf_q;
    unique case (1'b1)
      f3 == 3'b000: ld_data = {{24{buf_q[7]}}, buf_q[7:0]};
      f3 == 3'b001: ld_data = {{16{buf_q[15]}}, buf_q[15:0]};
      f3 == 3'b100: ld_data = {24'h0, buf_q[7:0]};
      f3 == 3'b101: ld_data = {16'h0, buf_q[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_mem) begin
            state_q <= ACCESS;
            cnt_q   <= 2'd0;
            buf_q   <= 32'h0;
          end
        end
        ACCESS: begin
          if (bus.mem_ack_i) begin
            if (is_ld) buf_q[{cnt_q, 3'b000} +: 8] <= bus.mem_din_i;
            if (cnt_q == last) state_q <= DONE;
            else cnt_q <= cnt_q + 2'd1;
          end
        end
        DONE: begin
          // wait out ctrl's hold so the same instruction is not replayed
          if (!hold_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        dout;

  always_comb begin
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'h0;
    stall_req_o = 1'b0;
    req         = 1'b0;
    we          = 1'b0;
    addr        = '0;
    dout        = 8'h0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          wd_o = wd_i;
          if (is_mem) begin
            stall_req_o = 1'b1;
          end else begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        ACCESS: begin
          wd_o        = wd_i;
          stall_req_o = 1'b1;
          req         = 1'b1;
          we          = is_st;
          addr        = mem_addr_i + ADDR_W'(cnt_q);
          dout        = wdata_i[{cnt_q, 3'b000} +: 8];
        end
        DONE: begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = is_ld ? ld_data : 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_o  = req;
  assign bus.mem_we_o   = we;
  assign bus.mem_addr_o = addr;
  assign bus.mem_dout_o = dout;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scoreboarded byte requests, load/store results.
// Ports: drives ex_mem inputs and plays the memory controller on bus.
module tb_mem_access;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPR   = 7'b0110011;

  logic        clk;
  logic        rst;
  logic [10:0] opcode_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic        hold_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;

  mem_access_if #(.ADDR_W(32)) bus ();

  mem_access #(.ADDR_W(32), .OPC_W(11)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode_i    (opcode_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_addr_i  (mem_addr_i),
    .hold_i      (hold_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  dout;
  } req_t;

  req_t        req_q[$];
  logic [31:0] res_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic pass_op(input logic [4:0] wd, input logic [31:0] d);
    @(negedge clk);
    opcode_i       = {1'b0, 3'b000, OPR};
    wd_i           = wd;
    wreg_i         = 1'b1;
    wdata_i        = d;
    bus.mem_ack_i  = 1'b1;
    #1;
    check("pt_wd", 32'(wd_o), 32'(wd));
    check("pt_wreg", 32'(wreg_o), 32'd1);
    check("pt_wdata", wdata_o, d);
    check("pt_stall", 32'(stall_req_o), 32'd0);
    check("pt_req", 32'(bus.mem_req_o), 32'd0);
  endtask

  task automatic do_mem(input logic [10:0] opc, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] wd,
                        input int nb, input logic [31:0] din_w,
                        input int dly, input logic [31:0] exp_res,
                        input int hold_n, input int abort_after);
    int          stalls;
    int          acks;
    int          w;
    bit          done;
    bit          st;
    logic [31:0] r;
    st = (opc[6:0] == STORE);
    @(negedge clk);
    opcode_i      = opc;
    mem_addr_i    = addr;
    wdata_i       = wdata;
    wd_i          = wd;
    wreg_i        = !st;
    bus.mem_ack_i = 1'b0;
    for (int i = 0; i < nb; i++)
      req_q.push_back('{addr + 32'(i), st, wdata[8*i +: 8]});
    res_q.push_back(exp_res);
    #1;
    check("idle_stall", 32'(stall_req_o), 32'd1);
    check("idle_req", 32'(bus.mem_req_o), 32'd0);
    check("idle_wreg", 32'(wreg_o), 32'd0);
    stalls = 1;
    acks   = 0;
    w      = 0;
    done   = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      if (abort_after > 0 && acks == abort_after) return;
      if (bus.mem_req_o) begin
        if (stall_req_o) stalls++;
        check("acc_wreg", 32'(wreg_o), 32'd0);
        if (req_q.size() == 0) begin
          check("extra_req", 32'd1, 32'd0);
        end else begin
          check("req_addr", bus.mem_addr_o, req_q[0].addr);
          check("req_we", 32'(bus.mem_we_o), 32'(req_q[0].we));
          if (st) check("req_dout", 32'(bus.mem_dout_o), 32'(req_q[0].dout));
          if (w == dly) begin
            bus.mem_ack_i = 1'b1;
            bus.mem_din_i = din_w[8*acks +: 8];
            void'(req_q.pop_front());
            acks++;
            w = 0;
          end else begin
            w++;
          end
        end
      end else if (!stall_req_o) begin
        done = 1'b1;
        r = res_q.pop_front();
        check("left_reqs", 32'(req_q.size()), 32'd0);
        check("stall_cnt", 32'(stalls), 32'(1 + nb * (dly + 1)));
        check("done_wdata", wdata_o, r);
        check("done_wd", 32'(wd_o), 32'(wd));
        check("done_wreg", 32'(wreg_o), 32'(!st));
        hold_i = (hold_n > 0);
        for (int k = 0; k < hold_n; k++) begin
          @(negedge clk);
          #1;
          if (k == hold_n - 1) hold_i = 1'b0;
          check("hold_req", 32'(bus.mem_req_o), 32'd0);
          check("hold_stall", 32'(stall_req_o), 32'd0);
          check("hold_wdata", wdata_o, r);
        end
      end else begin
        check("stall_no_req", 32'(bus.mem_req_o), 32'd1);
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_wd"}, 32'(wd_o), 32'd0);
    check({tag, "_wreg"}, 32'(wreg_o), 32'd0);
    check({tag, "_wdata"}, wdata_o, 32'd0);
    check({tag, "_stall"}, 32'(stall_req_o), 32'd0);
    check({tag, "_req"}, 32'(bus.mem_req_o), 32'd0);
    check({tag, "_we"}, 32'(bus.mem_we_o), 32'd0);
    check({tag, "_addr"}, bus.mem_addr_o, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    opcode_i      = {1'b0, 3'b000, OPR};
    wd_i          = 5'd7;
    wreg_i        = 1'b1;
    wdata_i       = 32'h42;
    mem_addr_i    = 32'h0;
    hold_i        = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.mem_din_i = 8'h0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("rst");
    rst = 1'b0;

    pass_op(5'd5, 32'h42);
    do_mem({1'b0, 3'b010, LOAD}, 32'h100, 32'h0, 5'd3, 4,
           32'h12345678, 0, 32'h12345678, 0, 0);
    pass_op(5'd1, 32'h11);
    do_mem({1'b0, 3'b000, LOAD}, 32'h80, 32'h0, 5'd4, 1,
           32'h80, 0, 32'hFFFFFF80, 0, 0);
    do_mem({1'b0, 3'b100, LOAD}, 32'h80, 32'h0, 5'd4, 1,
           32'h80, 1, 32'h00000080, 0, 0);
    do_mem({1'b0, 3'b001, LOAD}, 32'h90, 32'h0, 5'd6, 2,
           32'h00008000, 0, 32'hFFFF8000, 0, 0);
    do_mem({1'b0, 3'b101, LOAD}, 32'h91, 32'h0, 5'd6, 2,
           32'h00008000, 0, 32'h00008000, 0, 0);
    do_mem({1'b0, 3'b001, STORE}, 32'h203, 32'hABCD1234, 5'd0, 2,
           32'h0, 2, 32'h0, 0, 0);
    do_mem({1'b0, 3'b010, STORE}, 32'h400, 32'hCAFEF00D, 5'd0, 4,
           32'h0, 0, 32'h0, 0, 0);
    do_mem({1'b0, 3'b010, LOAD}, 32'hFFFFFFFE, 32'h0, 5'd9, 4,
           32'hDDCCBBAA, 0, 32'hDDCCBBAA, 3, 0);
    pass_op(5'd2, 32'h99);

    do_mem({1'b0, 3'b010, LOAD}, 32'h300, 32'h0, 5'd8, 4,
           32'h44332211, 0, 32'h0, 0, 2);
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    opcode_i = 11'h0;
    wd_i     = 5'd0;
    wreg_i   = 1'b0;
    wdata_i  = 32'h0;
    rst      = 1'b0;
    #1;
    chk_all_zero("post_abort");
    req_q.delete();
    res_q.delete();
    do_mem({1'b0, 3'b000, LOAD}, 32'h10, 32'h0, 5'd2, 1,
           32'h7F, 0, 32'h0000007F, 0, 0);
    pass_op(5'd31, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
